ethernet_frame_rx: RTL and testbench

// - Frame-level MII receive path: nibble stream (already in clk domain) -> validated Ethernet frames in a packet FIFO.
// - Strips preamble/SFD, assembles bytes low nibble first, checks FCS (CRC-32) and length, and optionally strips the FCS.
// - Commits good frames atomically; rolls back bad frames so the reader never sees them.
// - Sits after ethernet_init/ethernet_rx and replaces the plain nibble aggregator + byte FIFO.

---
 rtl/ethernet_frame_rx_pkg.sv | 28 ++
 rtl/ethernet_crc32_nibble.sv | 33 +++
 rtl/ethernet_frame_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ethernet_frame_rx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_frame_rx_pkg.sv
// Shared constants, FSM encoding and helpers for the MII frame receive path.
// Nibble codes and CRC-32 constants are given in their conventional (non-reflected) form.
package ethernet_frame_rx_pkg;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;

    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPreamble = 3'd1,
        StData     = 3'd2,
        StCommit   = 3'd3,
        StDrop     = 3'd4
    } rx_state_e;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ethernet_crc32_nibble.sv
// Reflected (LSB-first) CRC-32 engine consuming one MII nibble per enable.
// The register holds the reflected CRC state; init has priority over en.
module ethernet_crc32_nibble
    import ethernet_frame_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  nibble,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = bit_reverse32(CRC_POLY);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_step(crc, nibble);
        end
    end

endmodule

// File: rtl/ethernet_frame_rx.sv
// MII receive path: preamble/SFD strip, byte assembly, FCS and length checks, and a packet
// FIFO where good frames commit atomically and bad frames roll back invisibly to the reader.
module ethernet_frame_rx
    import ethernet_frame_rx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MIN_FRAME  = 64,
    parameter int unsigned MAX_FRAME  = 1518,
    parameter bit          CHECK_FCS  = 1'b1,
    parameter bit          STRIP_FCS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_dv,
    input  logic        nibble_valid,
    input  logic [3:0]  nibble,
    input  logic        rd,
    output logic [7:0]  r_data,
    output logic        r_last,
    output logic        empty,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    rx_state_e       state_q;
    ptr_t            wr_ptr_q;
    ptr_t            commit_ptr_q;
    ptr_t            rd_ptr_q;
    logic            phase_q;
    logic            seen_pre_q;
    logic [3:0]      low_nib_q;
    logic [15:0]     len_q;
    logic [4:0][7:0] hist_q;

    logic [8:0]      mem [DEPTH];

    logic [31:0]     crc;
    logic            crc_init;
    logic            crc_en;
    logic            nib_stb;
    logic            byte_done;
    logic            full;
    logic            len_max;
    logic            byte_err;
    logic            byte_wr;
    logic            pre_err;
    logic            eof_err;
    logic            frame_bad;
    logic [7:0]      new_byte;
    ptr_t            commit_end;
    ptr_t            last_ptr;
    logic            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [8:0]      mem_wdata;

    ethernet_crc32_nibble u_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init),
        .en     (crc_en),
        .nibble (nibble),
        .crc    (crc)
    );

    always_comb begin
        nib_stb   = rx_dv && nibble_valid;
        new_byte  = {nibble, low_nib_q};
        full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        len_max   = 32'(len_q) >= MAX_FRAME;
        byte_done = (state_q == StData) && nib_stb && phase_q;
        byte_err  = byte_done && (full || len_max);
        byte_wr   = byte_done && !byte_err;
        pre_err   = (state_q == StPreamble) && nib_stb && (nibble != PREAMBLE_NIB) &&
                    !((nibble == SFD_NIB) && seen_pre_q);
        // The engine is reflected, so compare against the bit-reversed residue.
        eof_err   = (state_q == StData) && !rx_dv &&
                    (phase_q || (32'(len_q) < MIN_FRAME) ||
                     (CHECK_FCS && (bit_reverse32(crc) != CRC_RESIDUE)));
        frame_bad = pre_err || byte_err || eof_err;
        crc_init  = (state_q == StPreamble) && nib_stb && (nibble == SFD_NIB) && seen_pre_q;
        crc_en    = (state_q == StData) && nib_stb;

        commit_end = wr_ptr_q - (STRIP_FCS ? ptr_t'(4) : ptr_t'(0));
        last_ptr   = commit_end - ptr_t'(1);

        mem_we    = byte_wr;
        mem_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
        mem_wdata = {1'b0, new_byte};
        // With the FCS stripped, the new last byte is the fifth most recent one written.
        if (state_q == StCommit) begin
            mem_we    = 1'b1;
            mem_addr  = last_ptr[ADDR_WIDTH-1:0];
            mem_wdata = {1'b1, (STRIP_FCS ? hist_q[4] : hist_q[0])};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign empty           = (rd_ptr_q == commit_ptr_q);
    assign {r_last, r_data} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            phase_q      <= 1'b0;
            seen_pre_q   <= 1'b0;
            low_nib_q    <= 4'd0;
            len_q        <= 16'd0;
            hist_q       <= '0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            frame_count  <= 16'd0;
            drop_count   <= 16'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (rd && !empty) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end

            if (frame_bad) begin
                wr_ptr_q  <= commit_ptr_q;
                frame_err <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
                state_q <= eof_err ? StIdle : StDrop;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_dv) begin
                            state_q    <= enable ? StPreamble : StDrop;
                            seen_pre_q <= 1'b0;
                        end
                    end
                    StPreamble: begin
                        if (!rx_dv) begin
                            state_q <= StIdle;
                        end else if (nibble_valid) begin
                            if (nibble == PREAMBLE_NIB) begin
                                seen_pre_q <= 1'b1;
                            end else begin
                                // Only a valid SFD reaches here; other nibbles raise pre_err.
                                state_q <= StData;
                                phase_q <= 1'b0;
                                len_q   <= 16'd0;
                            end
                        end
                    end
                    StData: begin
                        if (!rx_dv) begin
                            state_q <= StCommit;
                        end else if (nibble_valid) begin
                            if (!phase_q) begin
                                low_nib_q <= nibble;
                                phase_q   <= 1'b1;
                            end else begin
                                phase_q  <= 1'b0;
                                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
                                len_q    <= len_q + 16'd1;
                                hist_q   <= {hist_q[3:0], new_byte};
                            end
                        end
                    end
                    StCommit: begin
                        commit_ptr_q <= commit_end;
                        wr_ptr_q     <= commit_end;
                        frame_ok     <= 1'b1;
                        if (frame_count != 16'hFFFF) begin
                            frame_count <= frame_count + 16'd1;
                        end
                        state_q <= StIdle;
                    end
                    StDrop: begin
                        if (!rx_dv) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ethernet_frame_rx.sv
// Scoreboard bench: a default instance and a 64-entry instance share nibble stimulus;
// expected reader bytes are queued when a good frame is built and popped as the FIFO drains.
module tb_ethernet_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       enable;
    logic       rx_dv;
    logic       nibble_valid;
    logic [3:0] nibble;
    logic       rd;
    logic       tgt;

    logic dv_a, dv_b, rd_a, rd_b;
    assign dv_a = rx_dv & ~tgt;
    assign dv_b = rx_dv & tgt;
    assign rd_a = rd & ~tgt;
    assign rd_b = rd & tgt;

    logic [7:0]  r_data_a, r_data_b;
    logic        r_last_a, r_last_b, empty_a, empty_b;
    logic        ok_a, ok_b, err_a, err_b;
    logic [15:0] fc_a, fc_b, dc_a, dc_b;

    ethernet_frame_rx u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_dv        (dv_a),
        .nibble_valid (nibble_valid),
        .nibble       (nibble),
        .rd           (rd_a),
        .r_data       (r_data_a),
        .r_last       (r_last_a),
        .empty        (empty_a),
        .frame_ok     (ok_a),
        .frame_err    (err_a),
        .frame_count  (fc_a),
        .drop_count   (dc_a)
    );

    ethernet_frame_rx #(.ADDR_WIDTH(6)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_dv        (dv_b),
        .nibble_valid (nibble_valid),
        .nibble       (nibble),
        .rd           (rd_b),
        .r_data       (r_data_b),
        .r_last       (r_last_b),
        .empty        (empty_b),
        .frame_ok     (ok_b),
        .frame_err    (err_b),
        .frame_count  (fc_b),
        .drop_count   (dc_b)
    );

    logic       cur_empty, cur_last;
    logic [7:0] cur_data;
    assign cur_empty = tgt ? empty_b : empty_a;
    assign cur_last  = tgt ? r_last_b : r_last_a;
    assign cur_data  = tgt ? r_data_b : r_data_a;

    int n_ok_a = 0, n_err_a = 0, n_ok_b = 0, n_err_b = 0;
    always @(posedge clk) begin
        if (ok_a)  n_ok_a++;
        if (err_a) n_err_a++;
        if (ok_b)  n_ok_b++;
        if (err_b) n_err_b++;
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] frame_buf[$];
    logic [3:0] nib_buf[$];
    logic [8:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input int n, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        frame_buf.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'($urandom);
            frame_buf.push_back(b);
            c = c ^ {24'd0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frame_buf.push_back(c[8*k +: 8]);
        if (flip) frame_buf[5] = frame_buf[5] ^ 8'h10;
    endtask

    task automatic make_nibs(input bit extra);
        nib_buf.delete();
        for (int i = 0; i < 15; i++) nib_buf.push_back(4'h5);
        nib_buf.push_back(4'hD);
        foreach (frame_buf[i]) begin
            nib_buf.push_back(frame_buf[i][3:0]);
            nib_buf.push_back(frame_buf[i][7:4]);
        end
        if (extra) nib_buf.push_back(4'hA);
    endtask

    // Reader sees the frame minus its 4 FCS bytes, last flag on the final payload byte.
    task automatic expect_frame();
        int n;
        n = frame_buf.size() - 4;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), frame_buf[i]});
    endtask

    task automatic send_raw(input int lead, input bit drop_dv, input int tail);
        rx_dv = 1'b1;
        repeat (lead) tick();
        foreach (nib_buf[i]) begin
            nibble       = nib_buf[i];
            nibble_valid = 1'b1;
            tick();
            nibble_valid = 1'b0;
            tick();
        end
        if (drop_dv) begin
            rx_dv = 1'b0;
            repeat (tail) tick();
        end
    endtask

    task automatic drain(input string name);
        int guard;
        logic [8:0] e;
        guard = 0;
        while (!cur_empty && guard < 3000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s extra byte: got=%h expected=none", name, {cur_last, cur_data});
            end else begin
                e = exp_q.pop_front();
                if ({cur_last, cur_data} !== e) begin
                    failures++;
                    $display("FAIL %s byte: got=%h expected=%h", name, {cur_last, cur_data}, e);
                end
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing bytes: got=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({empty_a, ok_a, err_a} !== 3'b100) begin
            failures++;
            $display("FAIL reset_a flags: got=%b expected=100", {empty_a, ok_a, err_a});
        end
        checks++;
        if ({fc_a, dc_a} !== 32'd0) begin
            failures++;
            $display("FAIL reset_a counters: got=%h expected=0", {fc_a, dc_a});
        end
        checks++;
        if ({empty_b, ok_b, err_b} !== 3'b100) begin
            failures++;
            $display("FAIL reset_b flags: got=%b expected=100", {empty_b, ok_b, err_b});
        end
        checks++;
        if ({fc_b, dc_b} !== 32'd0) begin
            failures++;
            $display("FAIL reset_b counters: got=%h expected=0", {fc_b, dc_b});
        end
    endtask

    task automatic test_good_frame();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if (n_ok_a - ok0 !== 1) begin
            failures++; $display("FAIL good ok pulses: got=%0d expected=1", n_ok_a - ok0);
        end
        checks++;
        if (n_err_a - err0 !== 0) begin
            failures++; $display("FAIL good err pulses: got=%0d expected=0", n_err_a - err0);
        end
        checks++;
        if (fc_a !== 16'd1) begin
            failures++; $display("FAIL good frame_count: got=%0d expected=1", fc_a);
        end
        drain("good");
    endtask

    task automatic test_bad_fcs();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(64, 1'b1); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if ((n_err_a - err0 !== 1) || (n_ok_a - ok0 !== 0)) begin
            failures++;
            $display("FAIL bad_fcs pulses: got err=%0d ok=%0d expected err=1 ok=0",
                     n_err_a - err0, n_ok_a - ok0);
        end
        checks++;
        if ({empty_a, dc_a} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL bad_fcs empty/drop: got=%b/%0d expected=1/1", empty_a, dc_a);
        end
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if (fc_a !== 16'd2) begin
            failures++; $display("FAIL bad_fcs recovery count: got=%0d expected=2", fc_a);
        end
        drain("bad_fcs_next");
    endtask

    // Error frame with no FIFO effect; shared by runt, oversize, preamble and dribble cases.
    task automatic check_err_frame(input string name, input int err0, input int ok0,
                                   input logic [15:0] drops);
        checks++;
        if ((n_err_a - err0 !== 1) || (n_ok_a - ok0 !== 0)) begin
            failures++;
            $display("FAIL %s pulses: got err=%0d ok=%0d expected err=1 ok=0",
                     name, n_err_a - err0, n_ok_a - ok0);
        end
        checks++;
        if ({empty_a, dc_a} !== {1'b1, drops}) begin
            failures++;
            $display("FAIL %s empty/drop: got=%b/%0d expected=1/%0d", name, empty_a, dc_a, drops);
        end
    endtask

    task automatic test_length_errors();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(40, 1'b0); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        check_err_frame("runt", err0, ok0, 16'd2);
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(1525, 1'b0); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        check_err_frame("oversize", err0, ok0, 16'd3);
    endtask

    task automatic test_preamble_err();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        nib_buf = '{4'h5, 4'h5, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4};
        send_raw(2, 1'b1, 6);
        check_err_frame("preamble", err0, ok0, 16'd4);
    endtask

    task automatic test_disabled();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        enable = 1'b0;
        build_frame(64, 1'b0); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        enable = 1'b1;
        checks++;
        if ((n_err_a - err0 !== 0) || (n_ok_a - ok0 !== 0)) begin
            failures++;
            $display("FAIL disabled pulses: got err=%0d ok=%0d expected 0/0",
                     n_err_a - err0, n_ok_a - ok0);
        end
        checks++;
        if ({empty_a, fc_a, dc_a} !== {1'b1, 16'd2, 16'd4}) begin
            failures++;
            $display("FAIL disabled state: got=%b/%0d/%0d expected=1/2/4", empty_a, fc_a, dc_a);
        end
    endtask

    task automatic test_dribble();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(64, 1'b0); make_nibs(1'b1);
        send_raw(2, 1'b1, 6);
        check_err_frame("dribble", err0, ok0, 16'd5);
    endtask

    task automatic test_back_to_back();
        int ok0;
        ok0 = n_ok_a;
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 1);
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(0, 1'b1, 6);
        checks++;
        if ((n_ok_a - ok0 !== 2) || (fc_a !== 16'd4)) begin
            failures++;
            $display("FAIL back_to_back: got ok=%0d count=%0d expected ok=2 count=4",
                     n_ok_a - ok0, fc_a);
        end
        drain("back_to_back");
    endtask

    task automatic test_overflow();
        int ok0, err0;
        tgt = 1'b1;
        ok0 = n_ok_b; err0 = n_err_b;
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if ((n_ok_b - ok0 !== 1) || (fc_b !== 16'd1)) begin
            failures++;
            $display("FAIL ovf first: got ok=%0d count=%0d expected 1/1", n_ok_b - ok0, fc_b);
        end
        build_frame(64, 1'b0); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if ((n_err_b - err0 !== 1) || (dc_b !== 16'd1)) begin
            failures++;
            $display("FAIL ovf drop: got err=%0d drop=%0d expected 1/1", n_err_b - err0, dc_b);
        end
        drain("ovf_first");
        ok0 = n_ok_b;
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if ((n_ok_b - ok0 !== 1) || (fc_b !== 16'd2)) begin
            failures++;
            $display("FAIL ovf resend: got ok=%0d count=%0d expected 1/2", n_ok_b - ok0, fc_b);
        end
        drain("ovf_wrap");
        tgt = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ok0, err0;
        ok0 = n_ok_a; err0 = n_err_a;
        build_frame(64, 1'b0); make_nibs(1'b0);
        while (nib_buf.size() > 60) void'(nib_buf.pop_back());
        send_raw(2, 1'b0, 0);
        reset = 1'b1;
        repeat (3) tick();
        rx_dv = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ((n_ok_a - ok0 !== 0) || (n_err_a - err0 !== 0)) begin
            failures++;
            $display("FAIL reset_mid pulses: got ok=%0d err=%0d expected 0/0",
                     n_ok_a - ok0, n_err_a - err0);
        end
        checks++;
        if ({empty_a, fc_a, dc_a} !== {1'b1, 32'd0}) begin
            failures++;
            $display("FAIL reset_mid state: got=%b/%0d/%0d expected=1/0/0", empty_a, fc_a, dc_a);
        end
        build_frame(64, 1'b0); expect_frame(); make_nibs(1'b0);
        send_raw(2, 1'b1, 6);
        checks++;
        if (fc_a !== 16'd1) begin
            failures++; $display("FAIL reset_mid count: got=%0d expected=1", fc_a);
        end
        drain("reset_mid");
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        rx_dv        = 1'b0;
        nibble_valid = 1'b0;
        nibble       = 4'h0;
        rd           = 1'b0;
        tgt          = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_length_errors();
        test_preamble_err();
        test_disabled();
        test_dribble();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
